kbdmus_loader: RTL and testbench

KBDMUS_LOADER -- requirements
Module: kbdmus_loader

---
 rtl/kbdmus_loader.sv | 194 +++++++++++++++++++
 tb/tb_kbdmus_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kbdmus_loader.sv
`default_nettype none
// ============================================================================
// Module   : kbdmus_loader
// Purpose  : Turns SPI command/data bytes into keyboard and mouse updates.
//            Command 0x10 collects a 5-byte key bitmap. The first byte fills
//            kbd_out[7:0] and the last byte fills kbd_out[39:32].
//            Commands 0x20, 0x21 and 0x22 take one mouse byte for X, Y and
//            buttons. Any other command makes the loader ignore data until
//            the next command or end of transaction.
// Ports    : fclk, rst_n (async, active low)
//            spi_cmd/spi_cmd_stb, spi_data/spi_stb, spi_end  - SPI slave side
//            kbd_out/kbd_stb                                 - key bitmap
//            mus_out/mus_xstb/mus_ystb/mus_btnstb            - mouse byte
//            busy                                            - partial kbd frame
// Options  : define KBDMUS_TMO_EN to abort a stalled keyboard frame after
//            TMO_CYCLES idle cycles.
// Revision : 1.0  initial release
// ============================================================================
module kbdmus_loader #(
  parameter int TMO_CYCLES = 4096
) (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic [7:0]  spi_cmd,
  input  logic        spi_cmd_stb,
  input  logic [7:0]  spi_data,
  input  logic        spi_stb,
  input  logic        spi_end,
  output logic [39:0] kbd_out,
  output logic        kbd_stb,
  output logic [7:0]  mus_out,
  output logic        mus_xstb,
  output logic        mus_ystb,
  output logic        mus_btnstb,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KBD  = 2'd1,
    S_MUS  = 2'd2,
    S_SKIP = 2'd3
  } state_t;

  localparam logic [1:0] c_SEL_X   = 2'd0;
  localparam logic [1:0] c_SEL_Y   = 2'd1;
  localparam logic [1:0] c_SEL_BTN = 2'd2;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_mus_sel, w_mus_sel_nxt;
  // Only bytes 0..3 are held here. Byte 4 goes straight into kbd_out
  // together with them, so the strobe follows the last byte by one cycle.
  logic [31:0] r_shadow;
  logic [39:0] r_kbd_out;
  logic [7:0]  r_mus_out;
  logic        r_kbd_stb, r_xstb, r_ystb, r_btnstb;

  logic        w_kbd_byte;   // store a non-final keyboard byte
  logic        w_kbd_done;   // final (5th) keyboard byte
  logic        w_mus_ld;     // mouse byte accepted
  logic        w_tmo_hit;    // stalled keyboard frame expired

  assign busy = (r_state == S_KBD) && (r_cnt != 3'd0);

  // --------------------------------------------------------------------------
  // Optional inter-byte timeout for keyboard frames
  // --------------------------------------------------------------------------
`ifdef KBDMUS_TMO_EN
  localparam int c_TMO_W = $clog2(TMO_CYCLES + 1);

  logic [c_TMO_W-1:0] r_tmo;

  // Expiry is suppressed when a byte arrives in the same cycle, because that
  // byte restarts the idle window.
  assign w_tmo_hit = busy && !spi_stb && (r_tmo == c_TMO_W'(TMO_CYCLES - 1));

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (!busy || spi_stb || w_tmo_hit) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_mus_sel <= c_SEL_X;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mus_sel <= w_mus_sel_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // A command has top priority and drops any coincident data byte.
  // Otherwise a data byte is consumed first, and then spi_end (or the
  // timeout) forces IDLE. This lets a final byte that arrives together with
  // spi_end still complete its frame.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_mus_sel_nxt = r_mus_sel;
    w_kbd_byte    = 1'b0;
    w_kbd_done    = 1'b0;
    w_mus_ld      = 1'b0;

    if (spi_cmd_stb) begin
      w_cnt_nxt = 3'd0;
      case (spi_cmd)
        8'h10: w_state_nxt = S_KBD;
        8'h20: begin w_state_nxt = S_MUS; w_mus_sel_nxt = c_SEL_X;   end
        8'h21: begin w_state_nxt = S_MUS; w_mus_sel_nxt = c_SEL_Y;   end
        8'h22: begin w_state_nxt = S_MUS; w_mus_sel_nxt = c_SEL_BTN; end
        default: w_state_nxt = S_SKIP;
      endcase
    end else begin
      if (spi_stb) begin
        case (r_state)
          S_KBD: begin
            if (r_cnt == 3'd4) begin
              w_kbd_done  = 1'b1;
              w_cnt_nxt   = 3'd0;
              w_state_nxt = S_SKIP;
            end else begin
              w_kbd_byte  = 1'b1;
              w_cnt_nxt   = r_cnt + 3'd1;
            end
          end
          S_MUS: begin
            w_mus_ld    = 1'b1;
            w_state_nxt = S_SKIP;
          end
          default: ;  // IDLE and SKIP ignore data
        endcase
      end
      if (spi_end || w_tmo_hit) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Data path and strobes
  // --------------------------------------------------------------------------
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= 32'd0;
      r_kbd_out <= 40'd0;
      r_mus_out <= 8'd0;
      r_kbd_stb <= 1'b0;
      r_xstb    <= 1'b0;
      r_ystb    <= 1'b0;
      r_btnstb  <= 1'b0;
    end else begin
      if (w_kbd_byte) begin
        r_shadow[{r_cnt[1:0], 3'b000} +: 8] <= spi_data;
      end
      if (w_kbd_done) begin
        r_kbd_out <= {spi_data, r_shadow};
      end
      if (w_mus_ld) begin
        r_mus_out <= spi_data;
      end
      r_kbd_stb <= w_kbd_done;
      r_xstb    <= w_mus_ld && (r_mus_sel == c_SEL_X);
      r_ystb    <= w_mus_ld && (r_mus_sel == c_SEL_Y);
      r_btnstb  <= w_mus_ld && (r_mus_sel == c_SEL_BTN);
    end
  end

  assign kbd_out    = r_kbd_out;
  assign kbd_stb    = r_kbd_stb;
  assign mus_out    = r_mus_out;
  assign mus_xstb   = r_xstb;
  assign mus_ystb   = r_ystb;
  assign mus_btnstb = r_btnstb;

endmodule
`default_nettype wire

// File: tb/tb_kbdmus_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_kbdmus_loader
// Purpose  : Scoreboard bench for kbdmus_loader. Each driven byte that must
//            produce a strobe pushes {kind, data, cycle}. A negedge monitor
//            pops an entry for every strobe seen.
// Revision : 1.0  initial release
// ============================================================================
module tb_kbdmus_loader;

  localparam int TMO = 16;
  localparam int K_KBD = 0, K_X = 1, K_Y = 2, K_BTN = 3;

  logic        fclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  spi_cmd = 8'h00;
  logic        spi_cmd_stb = 1'b0;
  logic [7:0]  spi_data = 8'h00;
  logic        spi_stb = 1'b0;
  logic        spi_end = 1'b0;
  logic [39:0] kbd_out;
  logic        kbd_stb;
  logic [7:0]  mus_out;
  logic        mus_xstb, mus_ystb, mus_btnstb, busy;

  kbdmus_loader #(.TMO_CYCLES(TMO)) dut (
    .fclk(fclk), .rst_n(rst_n),
    .spi_cmd(spi_cmd), .spi_cmd_stb(spi_cmd_stb),
    .spi_data(spi_data), .spi_stb(spi_stb), .spi_end(spi_end),
    .kbd_out(kbd_out), .kbd_stb(kbd_stb),
    .mus_out(mus_out), .mus_xstb(mus_xstb), .mus_ystb(mus_ystb),
    .mus_btnstb(mus_btnstb), .busy(busy)
  );

  always #5 fclk = ~fclk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge fclk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [39:0] data;
    int          at;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // The strobe appears in the cycle after the byte is presented.
  task automatic expect_stb(input int kind, input logic [39:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.at   = cyc + 1;
    sb.push_back(e);
  endtask

  // Present inputs for one clock, then return 1 time unit after the edge.
  task automatic drive(input logic cs, input logic [7:0] c, input logic ds,
                       input logic [7:0] d, input logic e);
    spi_cmd_stb = cs; spi_cmd = c;
    spi_stb = ds; spi_data = d;
    spi_end = e;
    @(posedge fclk); #1;
    spi_cmd_stb = 1'b0; spi_stb = 1'b0; spi_end = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] c);
    drive(1'b1, c, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic byte_in(input logic [7:0] d);
    drive(1'b0, 8'h00, 1'b1, d, 1'b0);
  endtask

  task automatic end_pulse();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  // Strobe monitor / scoreboard consumer
  always @(negedge fclk) begin
    int          k;
    logic [39:0] v;
    exp_t        e;
    if (kbd_stb || mus_xstb || mus_ystb || mus_btnstb) begin
      check("strobe_onehot", 64'($countones({kbd_stb, mus_xstb, mus_ystb, mus_btnstb})), 64'd1);
      k = kbd_stb ? K_KBD : mus_xstb ? K_X : mus_ystb ? K_Y : K_BTN;
      v = kbd_stb ? kbd_out : {32'd0, mus_out};
      if (sb.size() == 0) begin
        check("unexpected_strobe", 64'(k + 1), 64'd0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind",  64'(k),   64'(e.kind));
        check("strobe_data",  64'(v),   64'(e.data));
        check("strobe_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  initial begin
    // Reset state
    idle(3);
    check("rst_kbd_out", 64'(kbd_out), 64'd0);
    check("rst_mus_out", 64'(mus_out), 64'd0);
    check("rst_strobes", 64'({kbd_stb, mus_xstb, mus_ystb, mus_btnstb}), 64'd0);
    check("rst_busy",    64'(busy), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Full keyboard frame, byte 0 lands in bits [7:0]
    cmd(8'h10);
    check("busy_after_cmd", 64'(busy), 64'd0);
    byte_in(8'h01); check("busy_b1", 64'(busy), 64'd1);
    byte_in(8'h02);
    byte_in(8'h04);
    byte_in(8'h08); check("busy_b4", 64'(busy), 64'd1);
    expect_stb(K_KBD, 40'h10_08_04_02_01);
    byte_in(8'h10);
    check("busy_after_frame", 64'(busy), 64'd0);
    byte_in(8'hFF);          // SKIP: ignored
    idle(2);
    check("kbd_hold", 64'(kbd_out), 64'h10_08_04_02_01);

    // Mouse Y, then a second byte which must be ignored
    cmd(8'h21);
    expect_stb(K_Y, 40'h7F);
    byte_in(8'h7F);
    byte_in(8'h55);
    idle(2);
    check("mus_hold", 64'(mus_out), 64'h7F);

    // Mouse X, then unknown command ignores data
    cmd(8'h20);
    expect_stb(K_X, 40'h81);
    byte_in(8'h81);
    cmd(8'h33);
    byte_in(8'h42);
    idle(2);
    check("mus_after_skip", 64'(mus_out), 64'h81);

    // Partial frame aborted by spi_end
    cmd(8'h10);
    byte_in(8'hA1); byte_in(8'hA2); byte_in(8'hA3);
    check("busy_partial", 64'(busy), 64'd1);
    end_pulse();
    check("busy_after_end", 64'(busy), 64'd0);
    byte_in(8'hA4); byte_in(8'hA5);   // IDLE: ignored
    idle(2);
    check("kbd_unchanged_abort", 64'(kbd_out), 64'h10_08_04_02_01);

    // A new command mid-frame restarts the byte counter
    cmd(8'h10);
    byte_in(8'h11); byte_in(8'h22);
    cmd(8'h10);
    check("busy_restart", 64'(busy), 64'd0);
    byte_in(8'h31); byte_in(8'h32); byte_in(8'h33); byte_in(8'h34);
    expect_stb(K_KBD, 40'h35_34_33_32_31);
    byte_in(8'h35);
    idle(2);

    // Fifth byte coincident with spi_end still completes the frame
    cmd(8'h10);
    byte_in(8'hAA); byte_in(8'hBB); byte_in(8'hCC); byte_in(8'hDD);
    expect_stb(K_KBD, 40'hEE_DD_CC_BB_AA);
    drive(1'b0, 8'h00, 1'b1, 8'hEE, 1'b1);
    byte_in(8'h77);                   // back in IDLE: ignored
    idle(2);
    check("kbd_end_frame", 64'(kbd_out), 64'hEE_DD_CC_BB_AA);

    // Command wins over coincident byte
    drive(1'b1, 8'h22, 1'b1, 8'h99, 1'b0);
    expect_stb(K_BTN, 40'h03);
    byte_in(8'h03);
    idle(2);
    check("mus_btn", 64'(mus_out), 64'h03);

    // Reset mid-frame
    cmd(8'h10);
    byte_in(8'h5A); byte_in(8'h5B);
    rst_n = 1'b0;
    #2;
    check("midrst_kbd_out", 64'(kbd_out), 64'd0);
    check("midrst_mus_out", 64'(mus_out), 64'd0);
    check("midrst_busy",    64'(busy), 64'd0);
    idle(2);
    rst_n = 1'b1;
    byte_in(8'h5C); byte_in(8'h5D); byte_in(8'h5E);   // IDLE after reset
    idle(3);
    check("postrst_busy", 64'(busy), 64'd0);
    check("postrst_kbd",  64'(kbd_out), 64'd0);

`ifdef KBDMUS_TMO_EN
    // Stalled frame expires after TMO idle cycles
    cmd(8'h10);
    byte_in(8'h01); byte_in(8'h02);
    idle(TMO - 1);
    check("tmo_busy_before", 64'(busy), 64'd1);
    idle(1);
    check("tmo_busy_after", 64'(busy), 64'd0);
    byte_in(8'h03); byte_in(8'h04); byte_in(8'h05);   // IDLE: no frame
    idle(3);
    check("tmo_kbd_out", 64'(kbd_out), 64'd0);
`else
    // Without the timeout a partial frame persists indefinitely
    cmd(8'h10);
    byte_in(8'h01); byte_in(8'h02);
    idle(3 * TMO);
    check("notmo_busy", 64'(busy), 64'd1);
    end_pulse();
    check("notmo_busy_end", 64'(busy), 64'd0);
    idle(3);
`endif

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
